// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: decodes format/immediate at the push, buffers up to two
// entries with a registered in_ready, and counts illegal encodings. Optional IMMGEN_ZIMM_EN.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;
    localparam logic [2:0] FMT_Z = 3'd6;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [6:0]        opc;
    logic signed [31:0] imm32;
    logic [2:0]        dec_fmt;
    logic              dec_illegal;
    entry_t            dec_entry;

    // Every immediate is first formed as a signed 32-bit value, then sign-extended to XLEN.
    always_comb begin
        opc         = in_instr[6:0];
        imm32       = '0;
        dec_fmt     = FMT_R;
        dec_illegal = 1'b0;
        if (in_instr[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end else begin
            case (opc)
                7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: begin
                    imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
                    dec_fmt = FMT_I;
                end
                7'b1110011: begin
                    imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
                    dec_fmt = FMT_I;
`ifdef IMMGEN_ZIMM_EN
                    if (in_instr[14]) begin
                        imm32   = {27'd0, in_instr[19:15]};
                        dec_fmt = FMT_Z;
                    end
`endif
                end
                7'b0100011: begin
                    imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                    dec_fmt = FMT_S;
                end
                7'b1100011: begin
                    imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                               in_instr[30:25], in_instr[11:8], 1'b0};
                    dec_fmt = FMT_B;
                end
                7'b0110111, 7'b0010111: begin
                    imm32   = {in_instr[31:12], 12'd0};
                    dec_fmt = FMT_U;
                end
                7'b1101111: begin
                    imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                               in_instr[20], in_instr[30:21], 1'b0};
                    dec_fmt = FMT_J;
                end
                7'b0110011: dec_fmt = FMT_R;
                7'b0011011: begin
                    if (XLEN == 64) begin
                        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
                        dec_fmt = FMT_I;
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end
                7'b0111011: dec_illegal = (XLEN != 64);
                default:    dec_illegal = 1'b1;
            endcase
        end
        dec_entry.imm     = XLEN'(imm32);
        dec_entry.fmt     = dec_fmt;
        dec_entry.illegal = dec_illegal;
        dec_entry.tag     = in_tag;
    end

    entry_t [1:0]     mem_q, mem_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push, pop;
    entry_t           head;

    assign head      = mem_q[rd_ptr_q];
    assign out_valid = (count_q != 2'd0);

    always_comb begin
        push     = in_valid & in_ready_q;
        pop      = out_valid & out_ready;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = dec_entry;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            if (head.illegal && (cnt_q != '1))
                cnt_d = cnt_q + CNT_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        // Registered ready looks at the next occupancy so it is exact every cycle.
        in_ready_d = (count_d != 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q      <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_imm     = head.imm;
    assign out_fmt     = head.fmt;
    assign out_illegal = head.illegal;
    assign out_tag     = head.tag;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 32-bit instance and a 64-bit instance with a 2-bit counter
// share the same stimulus.
module tb_imm_gen_pipe;

    logic        clk, rst_n, in_valid, out_ready;
    logic [31:0] in_instr, in_tag;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_imm, out_tag;
    logic [2:0]  out_fmt;
    logic [15:0] illegal_cnt;

    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [31:0] out_tag64;
    logic [2:0]  out_fmt64;
    logic [1:0]  illegal_cnt64;

    int n_checks = 0;
    int n_pass   = 0;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag),
        .illegal_cnt(illegal_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .CNT_W(2)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_tag(out_tag64),
        .illegal_cnt(illegal_cnt64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef IMMGEN_ZIMM_EN
    localparam logic [31:0] CSR_IMM = 32'h15;
    localparam logic [2:0]  CSR_FMT = 3'd6;
`else
    localparam logic [31:0] CSR_IMM = 32'h0;
    localparam logic [2:0]  CSR_FMT = 3'd1;
`endif

    localparam int NV = 15;
    logic [31:0] v_instr [NV] = '{
        32'hFFF00093, 32'hFE000FE3, 32'h800000B7, 32'hFEA12E23, 32'h008000EF,
        32'h8000006F, 32'h12345017, 32'h002081B3, 32'h80002083, 32'h00004501,
        32'h0010809B, 32'h000AD073, 32'h00B5053B, 32'h0FF0000F, 32'hFFFFFFFF};
    logic [31:0] e_imm [NV] = '{
        32'hFFFFFFFF, 32'hFFFFFFFE, 32'h80000000, 32'hFFFFFFFC, 32'h00000008,
        32'hFFF00000, 32'h12345000, 32'h0,        32'hFFFFF800, 32'h0,
        32'h0,        CSR_IMM,      32'h0,        32'h000000FF, 32'h0};
    logic [2:0] e_fmt [NV] = '{3'd1, 3'd3, 3'd4, 3'd2, 3'd5, 3'd5, 3'd4, 3'd0, 3'd1, 3'd0,
                               3'd0, CSR_FMT, 3'd0, 3'd1, 3'd0};
    logic e_ill [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                         1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [63:0] e_imm64 [NV] = '{
        64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFC,
        64'h8, 64'hFFFFFFFFFFF00000, 64'h12345000, 64'h0, 64'hFFFFFFFFFFFFF800, 64'h0,
        64'h1, {32'h0, CSR_IMM}, 64'h0, 64'hFF, 64'h0};
    logic [2:0] e_fmt64 [NV] = '{3'd1, 3'd3, 3'd4, 3'd2, 3'd5, 3'd5, 3'd4, 3'd0, 3'd1, 3'd0,
                                 3'd1, CSR_FMT, 3'd0, 3'd1, 3'd0};
    logic e_ill64 [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                           1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic apply_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        in_valid = 1'b0; out_ready = 1'b0; in_instr = '0; in_tag = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, in_ready, out_imm, out_fmt, out_illegal, out_tag, illegal_cnt} !==
            {1'b0, 1'b1, 32'h0, 3'd0, 1'b0, 32'h0, 16'h0})
            $display("FAIL reset32 valid=%b ready=%b imm=%h fmt=%0d ill=%b tag=%h cnt=%0d, want 0 1 0 0 0 0 0",
                     out_valid, in_ready, out_imm, out_fmt, out_illegal, out_tag, illegal_cnt);
        else n_pass++;
        n_checks++;
        if ({out_valid64, in_ready64, out_imm64, out_fmt64, out_illegal64, out_tag64, illegal_cnt64} !==
            {1'b0, 1'b1, 64'h0, 3'd0, 1'b0, 32'h0, 2'd0})
            $display("FAIL reset64 valid=%b ready=%b imm=%h fmt=%0d ill=%b tag=%h cnt=%0d, want 0 1 0 0 0 0 0",
                     out_valid64, in_ready64, out_imm64, out_fmt64, out_illegal64, out_tag64, illegal_cnt64);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    // Back-to-back pushes with out_ready=1: each entry is the head one cycle after acceptance.
    task automatic test_decode();
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1; in_instr = v_instr[i]; in_tag = 32'h1000 + i;
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, out_imm, out_fmt, out_illegal, out_tag} !==
                {1'b1, e_imm[i], e_fmt[i], e_ill[i], 32'h1000 + i})
                $display("FAIL decode32[%0d] instr=%h got v=%b imm=%h fmt=%0d ill=%b tag=%h want imm=%h fmt=%0d ill=%b",
                         i, v_instr[i], out_valid, out_imm, out_fmt, out_illegal, out_tag,
                         e_imm[i], e_fmt[i], e_ill[i]);
            else n_pass++;
            n_checks++;
            if ({out_valid64, out_imm64, out_fmt64, out_illegal64, out_tag64} !==
                {1'b1, e_imm64[i], e_fmt64[i], e_ill64[i], 32'h1000 + i})
                $display("FAIL decode64[%0d] instr=%h got v=%b imm=%h fmt=%0d ill=%b tag=%h want imm=%h fmt=%0d ill=%b",
                         i, v_instr[i], out_valid64, out_imm64, out_fmt64, out_illegal64, out_tag64,
                         e_imm64[i], e_fmt64[i], e_ill64[i]);
            else n_pass++;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL drain valid=%b ready=%b, want 0 1", out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_illegal();
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_instr = 32'h0; in_tag = 32'h2000 + i;
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, out_illegal, out_imm, out_fmt} !== {1'b1, 1'b1, 32'h0, 3'd0})
                $display("FAIL illegal_entry[%0d] v=%b ill=%b imm=%h fmt=%0d, want 1 1 0 0",
                         i, out_valid, out_illegal, out_imm, out_fmt);
            else n_pass++;
            if (i == 2) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
                n_checks++;
                if ({illegal_cnt, illegal_cnt64} !== {16'd3, 2'd3})
                    $display("FAIL illegal_cnt3 got %0d/%0d, want 3/3", illegal_cnt, illegal_cnt64);
                else n_pass++;
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({illegal_cnt, illegal_cnt64} !== {16'd5, 2'd3})
            $display("FAIL illegal_sat got %0d/%0d, want 5/3", illegal_cnt, illegal_cnt64);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        apply_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100093; in_tag = 32'hA;
        @(posedge clk); #1;
        in_instr = 32'h00200093; in_tag = 32'hB;
        @(posedge clk); #1;
        n_checks++;
        if ({in_ready, out_valid, out_imm} !== {1'b0, 1'b1, 32'd1})
            $display("FAIL bp_full ready=%b v=%b imm=%h, want 0 1 1", in_ready, out_valid, out_imm);
        else n_pass++;
        in_instr = 32'h00300093; in_tag = 32'hC;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({in_ready, out_valid, out_imm, out_tag} !== {1'b0, 1'b1, 32'd1, 32'hA})
                $display("FAIL bp_stall[%0d] ready=%b v=%b imm=%h tag=%h, want 0 1 1 a",
                         i, in_ready, out_valid, out_imm, out_tag);
            else n_pass++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({in_ready, out_valid, out_imm, out_tag} !== {1'b1, 1'b1, 32'd2, 32'hB})
            $display("FAIL bp_second ready=%b v=%b imm=%h tag=%h, want 1 1 2 b",
                     in_ready, out_valid, out_imm, out_tag);
        else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_imm, out_tag} !== {1'b1, 32'd3, 32'hC})
            $display("FAIL bp_third v=%b imm=%h tag=%h, want 1 3 c", out_valid, out_imm, out_tag);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0)
            $display("FAIL bp_empty v=%b, want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00700093; in_tag = 32'h7;
        repeat (2) @(posedge clk);
        #1 in_valid = 1'b0;
        n_checks++;
        if ({in_ready, out_valid} !== 2'b01)
            $display("FAIL mid_full ready=%b v=%b, want 0 1", in_ready, out_valid);
        else n_pass++;
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready, out_imm, out_tag, out_valid64, in_ready64} !==
            {1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1})
            $display("FAIL mid_async v=%b ready=%b imm=%h tag=%h v64=%b ready64=%b, want 0 1 0 0 0 1",
                     out_valid, in_ready, out_imm, out_tag, out_valid64, in_ready64);
        else n_pass++;
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'h00500093; in_tag = 32'h55;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_imm, out_fmt, out_tag} !== {1'b1, 32'd5, 3'd1, 32'h55})
            $display("FAIL mid_after v=%b imm=%h fmt=%0d tag=%h, want 1 5 1 55",
                     out_valid, out_imm, out_fmt, out_tag);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0)
            $display("FAIL mid_drain v=%b, want 0", out_valid);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_illegal();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
